dmem_responder: RTL

- Memory-side responder for the core's data-memory port. It serves word read and write requests over a valid/ready request channel and a valid/ready response channel.
- Inserts a fixed, parameterised access latency so the core can be exercised against non-ideal memory.
- Sits between the core's load/store path and the data storage array, and replaces the zero-wait combinational memory model in multi-cycle and stall testing.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with fixed, parameterised access latency.
//            Serves word loads/stores over valid/ready request and response
//            channels, flagging misaligned or out-of-range addresses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    // Counter only has to hold LATENCY-2, the WAIT-entry value.
    localparam int c_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'((LATENCY > 2) ? (LATENCY - 2) : 0);
    // With unit latency the accepting edge is also the edge entering RESP.
    localparam bit c_DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_write;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;
    logic                r_busy;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_src_write;
    logic [31:0]         w_src_addr;
    logic [31:0]         w_src_wdata;
    logic                w_err;
    logic [c_IDX_W-1:0]  w_idx;
    logic [31:0]         w_rdata;

    assign w_accept = req_valid && r_req_ready;

    // In IDLE the request is taken straight from the inputs (unit-latency
    // case); otherwise the latched copy drives decode and commit.
    assign w_src_write = (r_state == ST_IDLE) ? req_write : r_write;
    assign w_src_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_src_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_err   = (|w_src_addr[1:0]) || (|w_src_addr[31:c_IDX_W+2]);
    assign w_idx   = w_src_addr[c_IDX_W+1:2];
    assign w_rdata = (w_src_write || w_err) ? 32'd0 : r_mem[w_idx];

    assign w_enter_resp = ((r_state == ST_IDLE) && w_accept && c_DIRECT) ||
                          ((r_state == ST_WAIT) && (r_cnt == '0));

    // Storage array: cleared on reset, committed once on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_enter_resp && w_src_write && !w_err) begin
            r_mem[w_idx] <= w_src_wdata;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (c_DIRECT) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_rdata;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rdata;
                        r_resp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire
